// File: rtl/slv_ram_port_if.sv
// Request/response bundle between the cross_bar and a slave memory port.
// master: cross_bar side, drives req_* and observes req_rdy and rsp_*.
// slave : memory port side, drives req_rdy and rsp_*.
interface slv_ram_port_if;
    logic        req_vld;
    logic        req_cmd;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_rdy;
    logic        rsp_vld;
    logic        rsp_cmd;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_vld, req_cmd, req_addr, req_data,
        input  req_rdy, rsp_vld, rsp_cmd, rsp_data, rsp_err
    );

    modport slave (
        input  req_vld, req_cmd, req_addr, req_data,
        output req_rdy, rsp_vld, rsp_cmd, rsp_data, rsp_err
    );
endinterface

// File: rtl/slv_ram_port.sv
// Slave-side word RAM endpoint. Accepts one request at a time from the
// cross_bar, optionally waits WAIT_CYC cycles, performs the read or write and
// returns a single-cycle response strobe.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset (RAM contents are kept)
//   bus  - slv_ram_port_if.slave: req_vld/cmd/addr/data in, req_rdy out,
//          rsp_vld/cmd/data/err out
// Optional feature: define SLV_RAM_OOR_ERR_EN to flag requests whose
// addr[31] differs from SLV_ID or whose addr[30:AW] is non-zero; such writes
// are dropped, such reads return 32'hDEADBEEF, and rsp_err is raised.
module slv_ram_port #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned SLV_ID   = 0
) (
    input  logic           clk,
    input  logic           rst,
    slv_ram_port_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYC > 0) ? CW'(WAIT_CYC - 1) : '0;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          cmd_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic          rdy_q;
    logic          accept_c;
    logic          err_c;
    logic [31:0]   mem [DEPTH];

    // Ready is registered, so it is only ever high while the FSM sits in IDLE.
    assign accept_c = bus.req_vld && rdy_q;

`ifdef SLV_RAM_OOR_ERR_EN
    // Wrong slave select or any address bit beyond the RAM range.
    assign err_c = (bus.req_addr[31] != 1'(SLV_ID)) || (|bus.req_addr[30:AW]);
`else
    // Upper address bits and SLV_ID are deliberately ignored: addresses wrap.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[31:AW], 1'(SLV_ID)};
    assign err_c       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    next_state = (WAIT_CYC > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down to zero in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept_c) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request capture; the cross_bar may drop the request after the accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept_c) begin
            cmd_q  <= bus.req_cmd;
            idx_q  <= bus.req_addr[AW-1:0];
            data_q <= bus.req_data;
            err_q  <= err_c;
        end
    end

    // Word RAM, not reset so contents survive a port reset.
    always_ff @(posedge clk) begin
        if (state == ACCESS && cmd_q && !err_q) begin
            mem[idx_q] <= data_q;
        end
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q        <= 1'b0;
            bus.rsp_vld  <= 1'b0;
            bus.rsp_cmd  <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else begin
            rdy_q       <= (next_state == IDLE);
            bus.rsp_vld <= (state == ACCESS);
            if (state == ACCESS) begin
                bus.rsp_cmd <= cmd_q;
                bus.rsp_err <= err_q;
                if (cmd_q) begin
                    bus.rsp_data <= '0;
                end else if (err_q) begin
                    bus.rsp_data <= ERR_DATA;
                end else begin
                    bus.rsp_data <= mem[idx_q];
                end
            end
        end
    end

    assign bus.req_rdy = rdy_q;

endmodule

// File: doc/slv_ram_port.md
Name: slv_ram_port

Overview:
- Slave-side memory endpoint directly downstream of the cross_bar.
- Consumes one routed master request at a time (cmd/addr/data) and performs a write or read on an internal word RAM.
- Returns a one-cycle response (read data or write ack) back toward the cross_bar.
- Programmable wait states emulate slow slaves, so arbitration and master stall paths are exercised.

Parameters:
- DEPTH, 16: number of 32-bit words; power of two, 2..256. AW = $clog2(DEPTH).
- WAIT_CYC, 0: extra wait cycles between accept and memory access; 0..15.
- SLV_ID, 0: value of addr[31] this port answers to; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  1  request valid from cross_bar.
- req_cmd  in  1  1 = write, 0 = read.
- req_addr  in  32  word address; bit 31 is the slave select.
- req_data  in  32  write data.
- req_rdy  out  1  port can accept a request this cycle.
- rsp_vld  out  1  one-cycle response strobe.
- rsp_cmd  out  1  echo of the accepted req_cmd.
- rsp_data  out  32  read data; 0 for write responses.
- rsp_err  out  1  error flag, qualified by rsp_vld.

Behaviour:
- Reset values (async, immediate on rst high):
  - state = IDLE.
  - req_rdy = 1 after reset is released; it is held 0 while rst is high.
  - rsp_vld = 0, rsp_cmd = 0, rsp_data = 0, rsp_err = 0.
  - Wait counter = 0.
  - RAM contents are NOT cleared by reset and persist across reset.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - req_rdy = 1.
  - On req_vld at a rising edge, latch cmd, addr[AW-1:0], data and the full address.
  - Next state is WAIT if WAIT_CYC > 0, otherwise ACCESS.
  - Counter loads WAIT_CYC-1.
- WAIT:
  - req_rdy = 0.
  - Counter decrements each cycle; at 0, go to ACCESS.
  - WAIT lasts exactly WAIT_CYC cycles.
- ACCESS:
  - req_rdy = 0.
  - On the exiting edge:
    - write: RAM[idx] <= latched data;
    - read: rsp_data <= RAM[idx].
  - On the same edge: rsp_vld <= 1, rsp_cmd <= latched cmd, state <= IDLE.
- Latency: rsp_vld is high during the cycle starting WAIT_CYC+1 edges after the accepting edge. It is high for exactly one cycle, then returns to 0.
- rsp_data and rsp_cmd hold their values until the next response.
- Back-to-back: a new request may be accepted on the edge following ACCESS, while rsp_vld is still high. There is no bubble beyond the response cycle itself.
- req_vld while req_rdy = 0 is ignored. Inputs are not sampled; the cross_bar must hold the request.
- Read-after-write to the same address returns the new data. The write completes at the ACCESS edge, before any later accept.
- Address handling without the feature: idx = req_addr[AW-1:0]. Upper bits are ignored, so addresses wrap modulo DEPTH.
- Reset mid-operation: the in-flight request is dropped with no response. A write that has not reached ACCESS never reaches RAM.

Optional Feature:
- Macro: SLV_RAM_OOR_ERR_EN.
- Defined: a request is in error if req_addr[31] != SLV_ID, or if any bit of req_addr[30:AW] is 1.
  - Erroneous write: RAM is not modified.
  - Erroneous read: rsp_data = 32'hDEADBEEF.
  - rsp_err = 1 with rsp_vld.
  - Timing is identical to a normal access.
- Undefined: no range check; addresses wrap as above; rsp_err is tied to 0.

Test Plan:
- Reset then idle:
  - stimulus: rst pulse mid-cycle, no req_vld;
  - required: rsp_vld = 0, rsp_data = 0, and req_rdy = 1 on the first edge after rst falls.
- Write/read burst, WAIT_CYC = 0:
  - stimulus: write 32'h11..32'h18 to addr 0..7, then read 0..7;
  - required: each rsp_vld arrives 1 cycle after its accept, and reads return 32'h11..32'h18 in order.
- Wait states, WAIT_CYC = 3:
  - stimulus: write 32'h51 to addr 2, then read addr 2;
  - required: req_rdy is low for 4 cycles after each accept, rsp_vld comes 4 cycles after accept, and the read returns 32'h51.
- Wrap, DEPTH = 16, macro off:
  - stimulus: write 32'hA1 to addr 32'h00000013, then read addr 3;
  - required: returns 32'hA1, rsp_err = 0.
- Out of range, macro on, SLV_ID = 0:
  - stimulus: write 32'hA5 to 32'h80000001, then read addr 1;
  - required: first response has rsp_err = 1; the read of addr 1 returns the prior contents unchanged.
  - stimulus: read 32'h00000100;
  - required: returns 32'hDEADBEEF with rsp_err = 1.
- Reset mid-op, WAIT_CYC = 5:
  - stimulus: write 32'hFF to addr 4, assert rst during WAIT, then read addr 4;
  - required: no response for the aborted write, and addr 4 holds its previous value.
